audio_mux_mc: RTL and testbench

//  Multi-channel successor of the stereo audio bus mux. Sits between the per-voice/mixer

---
 rtl/audio_mux_pkg.sv | 23 ++
 rtl/audio_mux_mc_fill_ctrl.sv | 51 +++++
 rtl/audio_mux_mc.sv | 103 ++++++++++
 tb/tb_audio_mux_mc.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/audio_mux_pkg.sv
// Shared register-map offsets, widths and read-data packing for the audio mux.
package audio_mux_pkg;

  localparam int UNDERRUN_W = 8;

  function automatic int unsigned ctrl_off(input int unsigned n);
    return n;
  endfunction

  function automatic int unsigned bufsize_off(input int unsigned n);
    return n + 1;
  endfunction

  function automatic int unsigned status_off(input int unsigned n);
    return n + 2;
  endfunction

  // Samples are left-justified in the 32-bit read word.
  function automatic logic [31:0] pack_dataout(input logic [31:0] smp, input int unsigned sw);
    return smp << (32 - sw);
  endfunction

endpackage

// File: rtl/audio_mux_mc_fill_ctrl.sv
// FIFO-fill trigger handshake: jack cycle edge detect, fill counter, trigger pulse
// and saturating underrun counter.
module fifo_fill_ctrl
  import audio_mux_pkg::*;
#(
  parameter int CW = 7
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  jack_read_act,
  input  logic [CW-1:0]         buffersize,
  input  logic                  xxxx_top,
  input  logic                  run,
  input  logic                  status_clr,
  output logic [CW-1:0]         counter,
  output logic                  fill,
  output logic                  run_trig,
  output logic [UNDERRUN_W-1:0] underrun_cnt
);

  logic jack_read_act_dly;
  logic jack_cycle_end;

  assign jack_cycle_end = jack_read_act_dly & ~jack_read_act;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jack_read_act_dly <= 1'b0;
      counter           <= '0;
      fill              <= 1'b0;
      run_trig          <= 1'b0;
      underrun_cnt      <= '0;
    end else begin
      jack_read_act_dly <= jack_read_act;
      if (jack_cycle_end) begin
        counter <= '0;
        if (counter < buffersize && underrun_cnt != '1)
          underrun_cnt <= underrun_cnt + 1'b1;
      end else if (counter < buffersize) begin
        fill <= 1'b1;
        if (run_trig) counter <= counter + 1'b1;
      end else begin
        fill <= 1'b0;
      end
      // A host clear overrides an increment landing in the same cycle.
      if (status_clr) underrun_cnt <= '0;
      run_trig <= xxxx_top & fill & ~run;
    end
  end

endmodule

// File: rtl/audio_mux_mc.sv
// Multi-channel audio bus mux: coherent lrck snapshot of NUM_CH samples served over
// a word register port, plus the fill-trigger handshake.
module audio_mux_mc
  import audio_mux_pkg::*;
#(
  parameter int NUM_CH     = 8,
  parameter int SAMPLE_W   = 24,
  parameter int FIFO_WIDTH = 6,
  parameter int ADDR_W     = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [ADDR_W-1:0]          address,
  input  logic                       read,
  input  logic                       write,
  input  logic [31:0]                datain,
  input  logic [NUM_CH*SAMPLE_W-1:0] sound_in,
  input  logic                       xxxx_top,
  input  logic                       lrck,
  input  logic                       run,
  output logic [31:0]                dataout,
  output logic [NUM_CH-1:0]          ch_read,
  output logic                       sample_ready,
  output logic                       underrun,
  output logic                       trig
);

  localparam int CW = FIFO_WIDTH + 1;
  localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(ctrl_off(NUM_CH));
  localparam logic [ADDR_W-1:0] A_BUFSIZE = ADDR_W'(bufsize_off(NUM_CH));
  localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(status_off(NUM_CH));
  localparam logic [ADDR_W-1:0] A_LAST_CH = ADDR_W'(NUM_CH - 1);

  logic [NUM_CH-1:0][SAMPLE_W-1:0] shadow;
  logic                            lrck_dly;
  logic                            snap;
  logic                            jack_read_act;
  logic [CW-1:0]                   buffersize;
  logic [CW-1:0]                   counter;
  logic                            fill;
  logic                            run_trig;
  logic [UNDERRUN_W-1:0]           underrun_cnt;
  logic                            status_clr;
  logic [31:0]                     rd_data;
  logic                            unused_datain;

  assign unused_datain = ^datain[31:CW] ^ fill;
  assign snap          = lrck & ~lrck_dly;
  assign status_clr    = write && address == A_STATUS;
  assign underrun      = underrun_cnt != '0;
  assign trig          = (buffersize == '0) ? lrck : run_trig;

  always_comb begin
    ch_read = '0;
    for (int i = 0; i < NUM_CH; i++)
      ch_read[i] = read && address == ADDR_W'(i);
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (address == ADDR_W'(i)) rd_data = pack_dataout(32'(shadow[i]), SAMPLE_W);
    if (address == A_BUFSIZE) rd_data = 32'(buffersize);
    if (address == A_STATUS)  rd_data = 32'({underrun_cnt, counter});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dataout       <= '0;
      shadow        <= '0;
      lrck_dly      <= 1'b0;
      jack_read_act <= 1'b0;
      buffersize    <= '0;
      sample_ready  <= 1'b0;
    end else begin
      lrck_dly <= lrck;
      // Reads see the shadow as it was before this cycle's snapshot.
      if (read) dataout <= rd_data;
      if (snap)
        for (int i = 0; i < NUM_CH; i++)
          shadow[i] <= sound_in[i*SAMPLE_W +: SAMPLE_W];
      if (write && address == A_CTRL)    jack_read_act <= datain[0];
      if (write && address == A_BUFSIZE) buffersize    <= datain[CW-1:0];
      if (snap)                                 sample_ready <= 1'b1;
      else if (read && address == A_LAST_CH)    sample_ready <= 1'b0;
    end
  end

  fifo_fill_ctrl #(.CW(CW)) u_fill (
    .clk          (clk),
    .reset_n      (reset_n),
    .jack_read_act(jack_read_act),
    .buffersize   (buffersize),
    .xxxx_top     (xxxx_top),
    .run          (run),
    .status_clr   (status_clr),
    .counter      (counter),
    .fill         (fill),
    .run_trig     (run_trig),
    .underrun_cnt (underrun_cnt)
  );

endmodule

// File: tb/tb_audio_mux_mc.sv
// Directed bench for audio_mux_mc: register map, snapshot, fill handshake, underrun, reset.
module tb_audio_mux_mc;
  localparam int NUM_CH = 8, SAMPLE_W = 24, FIFO_WIDTH = 6, ADDR_W = 4;
  localparam logic [ADDR_W-1:0] A_CTRL = 4'd8, A_BUF = 4'd9, A_STAT = 4'd10;

  logic                       clk = 1'b0;
  logic                       reset_n = 1'b0;
  logic [ADDR_W-1:0]          address = '0;
  logic                       read = 1'b0, write = 1'b0;
  logic [31:0]                datain = '0;
  logic [NUM_CH*SAMPLE_W-1:0] sound_in = '0;
  logic                       xxxx_top = 1'b0, lrck = 1'b0, run = 1'b0;
  logic [31:0]                dataout;
  logic [NUM_CH-1:0]          ch_read;
  logic                       sample_ready, underrun, trig;

  int n_vec = 0, n_bad = 0, trig_cnt = 0, t0 = 0;
  logic [31:0] d;

  audio_mux_mc #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .FIFO_WIDTH(FIFO_WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .datain(datain), .sound_in(sound_in), .xxxx_top(xxxx_top), .lrck(lrck), .run(run),
    .dataout(dataout), .ch_read(ch_read), .sample_ready(sample_ready),
    .underrun(underrun), .trig(trig)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (trig) trig_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] v);
    address = a; datain = v; write = 1'b1; tick(); write = 1'b0;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, output logic [31:0] v);
    address = a; read = 1'b1; tick(); read = 1'b0; v = dataout;
  endtask

  task automatic pulse();
    xxxx_top = 1'b1; tick(); xxxx_top = 1'b0; repeat (3) tick();
  endtask

  task automatic load(input logic [23:0] base);
    for (int i = 0; i < NUM_CH; i++) sound_in[i*SAMPLE_W +: SAMPLE_W] = base + 24'(i);
  endtask

  initial begin
    repeat (3) @(posedge clk); #1;
    check("rst_dataout", dataout, 32'h0);
    check("rst_ready", {31'b0, sample_ready}, 32'h0);
    check("rst_underrun", {31'b0, underrun}, 32'h0);
    check("rst_trig", {31'b0, trig}, 32'h0);
    reset_n = 1'b1; tick();

    // Snapshot and channel read
    load(24'h100000);
    lrck = 1'b1; tick(); lrck = 1'b0; tick();
    address = 4'd3; read = 1'b1; #1;
    check("ch_read3", {24'b0, ch_read}, 32'h08);
    tick(); read = 1'b0;
    check("rd_ch3", dataout, 32'h10000300);
    check("ready_set", {31'b0, sample_ready}, 32'h1);
    address = A_STAT; read = 1'b1; #1;
    check("ch_read_stat", {24'b0, ch_read}, 32'h0);
    read = 1'b0; tick();
    check("dataout_hold", dataout, 32'h10000300);

    // Snapshot and read of last channel in one cycle
    load(24'h200000);
    lrck = 1'b1; address = 4'd7; read = 1'b1; tick(); read = 1'b0; lrck = 1'b0;
    check("rd_ch7_old", dataout, 32'h10000700);
    check("ready_wins", {31'b0, sample_ready}, 32'h1);
    rd(4'd7, d);
    check("rd_ch7_new", d, 32'h20000700);
    check("ready_clr", {31'b0, sample_ready}, 32'h0);
    rd(4'd12, d);
    check("rd_unmapped", d, 32'h0);

    // Bypass then fill handshake
    lrck = 1'b1; #1;
    check("bypass_hi", {31'b0, trig}, 32'h1);
    tick(); lrck = 1'b0; #1;
    check("bypass_lo", {31'b0, trig}, 32'h0);
    wr(A_BUF, 32'd4);
    lrck = 1'b1; #1;
    check("no_bypass", {31'b0, trig}, 32'h0);
    lrck = 1'b0; repeat (2) tick();
    t0 = trig_cnt;
    repeat (6) pulse();
    check("trig_count4", 32'(trig_cnt - t0), 32'd4);
    rd(A_STAT, d);
    check("stat_fill4", d, 32'h4);
    rd(A_BUF, d);
    check("rd_bufsize", d, 32'h4);

    // One underrun from a short jack cycle
    wr(A_CTRL, 32'd1); wr(A_CTRL, 32'd0); repeat (2) tick();
    rd(A_STAT, d);
    check("full_end_no_ur", d, 32'h0);
    repeat (2) pulse();
    rd(A_STAT, d);
    check("stat_fill2", d, 32'h2);
    wr(A_CTRL, 32'd1); wr(A_CTRL, 32'd0); repeat (2) tick();
    rd(A_STAT, d);
    check("stat_ur1", d, 32'h80);
    check("underrun_flag", {31'b0, underrun}, 32'h1);
    wr(A_STAT, 32'h0); tick();
    rd(A_STAT, d);
    check("stat_cleared", d, 32'h0);

    // Saturation, then run blocks triggers
    for (int i = 0; i < 300; i++) begin
      wr(A_CTRL, 32'd1); wr(A_CTRL, 32'd0);
    end
    repeat (2) tick();
    rd(A_STAT, d);
    check("stat_ur255", d, 32'h7f80);
    run = 1'b1; t0 = trig_cnt;
    repeat (3) pulse();
    check("run_blocks", 32'(trig_cnt - t0), 32'd0);
    run = 1'b0; t0 = trig_cnt;
    pulse();
    check("run_released", 32'(trig_cnt - t0), 32'd1);

    // Asynchronous reset mid-fill
    lrck = 1'b1; tick(); lrck = 1'b0; rd(4'd0, d);
    check("pre_rst_ready", {31'b0, sample_ready}, 32'h1);
    @(posedge clk); #2 reset_n = 1'b0; #1;
    check("arst_dataout", dataout, 32'h0);
    check("arst_ready", {31'b0, sample_ready}, 32'h0);
    check("arst_underrun", {31'b0, underrun}, 32'h0);
    check("arst_trig", {31'b0, trig}, 32'h0);
    #8 reset_n = 1'b1; tick();
    rd(A_STAT, d);
    check("post_rst_stat", d, 32'h0);
    rd(A_BUF, d);
    check("post_rst_buf", d, 32'h0);
    load(24'h300000);
    lrck = 1'b1; tick(); lrck = 1'b0;
    rd(4'd0, d);
    check("post_rst_snap", d, 32'h30000000);
    check("post_rst_ready", {31'b0, sample_ready}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
